// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front-end: FSM states,
// PC step and the queue-space helper.
package fetch_unit_pkg;

    localparam int FETCH_STATESIZE = 2;
    localparam int PC_STEP         = 4;

    typedef enum logic [FETCH_STATESIZE-1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    // Occupancy counts queued entries plus the request still in flight.
    function automatic logic fetch_has_space(input int unsigned occupancy,
                                             input int unsigned depth);
        return (occupancy < depth);
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch queue of (pc, instruction) pairs; head is presented combinationally
// and reads as zero when the queue is empty.
module fetch_fifo #(
    parameter int PW    = 64,
    parameter int IW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [PW-1:0]              i_pc,
    input  logic [IW-1:0]              i_inst,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_valid,
    output logic [PW-1:0]              o_pc,
    output logic [IW-1:0]              o_inst
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0] r_pc_mem   [DEPTH];
    logic [IW-1:0] r_inst_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop & (r_count != {CW{1'b0}});
    assign w_do_push = i_push & ((r_count != CW'(DEPTH)) | w_do_pop);

    // Storage, pointers and occupancy; flush empties the queue in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= {PW{1'b0}};
                r_inst_mem[i] <= {IW{1'b0}};
            end
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_flush) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_pc_mem[r_wr_ptr]   <= i_pc;
                r_inst_mem[r_wr_ptr] <= i_inst;
                r_wr_ptr             <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head view; zeroed when empty so IF-ID sees a clean nop.
    always_comb begin
        o_pc   = {PW{1'b0}};
        o_inst = {IW{1'b0}};
        if (r_count != {CW{1'b0}}) begin
            o_pc   = r_pc_mem[r_rd_ptr];
            o_inst = r_inst_mem[r_rd_ptr];
        end else begin
            o_pc   = {PW{1'b0}};
            o_inst = {IW{1'b0}};
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != {CW{1'b0}});

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: handshaked variable-latency memory port feeding
// a prefetch queue, with hazard stall and write-back branch redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  WORDSIZE = 64,
    parameter int                  INSTSIZE = 32,
    parameter int                  DEPTH    = 4,
    parameter logic [WORDSIZE-1:0] RESETPC  = {WORDSIZE{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [WORDSIZE-1:0] redirect_pc,
    output logic                imem_req,
    output logic [WORDSIZE-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [INSTSIZE-1:0] imem_data,
    output logic                out_valid,
    output logic [WORDSIZE-1:0] out_pc,
    output logic [INSTSIZE-1:0] out_inst
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e        r_state;
    logic [WORDSIZE-1:0] r_fetch_pc;
    logic [WORDSIZE-1:0] r_addr;
    logic                r_req;

    logic [CW-1:0]       w_count;
    logic                w_head_valid;
    logic                w_pop;
    logic                w_push;
    logic                w_inflight;
    logic                w_space;
    logic [WORDSIZE-1:0] w_next_pc;

    assign w_pop      = w_head_valid & ~stall & ~redirect;
    assign w_push     = imem_ack & (r_state == FETCH_WAIT) & ~redirect;
    assign w_inflight = (r_state == FETCH_WAIT);
    assign w_next_pc  = r_fetch_pc + WORDSIZE'(PC_STEP);
    // An acked request turns into a queued entry, so it still counts once.
    assign w_space    = fetch_has_space(32'(w_count) - 32'(w_pop) + 32'(w_inflight),
                                        32'(DEPTH));

    fetch_fifo #(
        .PW    (WORDSIZE),
        .IW    (INSTSIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_pc    (r_addr),
        .i_inst  (imem_data),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_count (w_count),
        .o_valid (w_head_valid),
        .o_pc    (out_pc),
        .o_inst  (out_inst)
    );

    // Request FSM; redirect outranks everything, a stale ack is absorbed in DROP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= FETCH_IDLE;
            r_fetch_pc <= RESETPC;
            r_req      <= 1'b0;
            r_addr     <= RESETPC;
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                    end else if (w_space) begin
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                        r_state <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                        r_req      <= 1'b0;
                        r_state    <= imem_ack ? FETCH_IDLE : FETCH_DROP;
                    end else if (imem_ack) begin
                        r_fetch_pc <= w_next_pc;
                        if (w_space) begin
                            r_addr <= w_next_pc;
                        end else begin
                            r_req   <= 1'b0;
                            r_state <= FETCH_IDLE;
                        end
                    end
                end
                FETCH_DROP: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                    end
                    if (imem_ack) begin
                        r_state <= FETCH_IDLE;
                    end
                end
                default: begin
                    r_state <= FETCH_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign out_valid = w_head_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory responder.
module tb_fetch_unit;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        stall       = 1'b0;
    logic        redirect    = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .WORDSIZE (64),
        .INSTSIZE (32),
        .DEPTH    (4),
        .RESETPC  (64'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_5A5A;
    endfunction

    // Memory responder: one ack per request, `lat` edges after it first sees req.
    int          lat       = 1;
    logic        m_ack     = 1'b0;
    logic        m_busy    = 1'b0;
    int          m_cnt     = 0;
    logic [63:0] m_addr    = 64'd0;
    logic [31:0] m_data    = 32'd0;
    logic        spur      = 1'b0;
    logic [31:0] spur_data = 32'd0;

    assign imem_ack  = m_ack | spur;
    assign imem_data = spur ? spur_data : m_data;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_ack) begin
            m_ack  <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_ack  <= 1'b1;
                m_data <= mem_f(m_addr);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (imem_req) begin
            m_busy <= 1'b1;
            m_addr <= imem_addr;
            if (lat <= 1) begin
                m_ack  <= 1'b1;
                m_data <= mem_f(imem_addr);
            end else begin
                m_cnt <= lat - 1;
            end
        end
    end

    // Pop log and request-stability monitor, sampled on the falling edge.
    logic [63:0] pc_q[$];
    logic [31:0] inst_q[$];
    int          cyc_q[$];
    logic        p_req  = 1'b0;
    logic        p_ack  = 1'b0;
    logic [63:0] p_addr = 64'd0;

    always @(negedge clk) begin
        if (rst && out_valid && !stall && !redirect) begin
            pc_q.push_back(out_pc);
            inst_q.push_back(out_inst);
            cyc_q.push_back(cyc);
        end
        if (rst && p_req && !p_ack && imem_req) begin
            chk("addr_stable", imem_addr, p_addr);
        end
        p_req  = imem_req & rst;
        p_ack  = imem_ack;
        p_addr = imem_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l, input logic st);
        rst   = 1'b0;
        lat   = l;
        stall = st;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    int   b;
    logic ok;

    initial begin
        // T1: reset values, first-fetch latency, in-order stream
        #2 rst = 1'b0;
        lat = 1;
        repeat (3) tick();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 64'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_inst", out_inst, 32'd0);
        b = pc_q.size();
        rst = 1'b1;
        tick();
        chk("t1_req_first", imem_req, 1'b1);
        chk("t1_addr_first", imem_addr, 64'd0);
        tick();
        chk("t1_ack", imem_ack, 1'b1);
        chk("t1_valid_pre", out_valid, 1'b0);
        tick();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_pc0", out_pc, 64'd0);
        chk("t1_inst0", out_inst, 64'(mem_f(64'd0)));
        chk("t1_addr4", imem_addr, 64'd4);
        repeat (14) tick();
        for (int i = 0; i < 6; i++) begin
            chk("t1_pop_pc", pc_q[b+i], 64'(i * 4));
            chk("t1_pop_inst", inst_q[b+i], 64'(mem_f(64'(i * 4))));
        end

        // T2: stall fills the queue, spurious ack ignored, drain back-to-back
        do_reset(1, 1'b1);
        b = pc_q.size();
        repeat (14) tick();
        chk("t2_head_pc", out_pc, 64'd0);
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_req_low", imem_req, 1'b0);
        chk("t2_no_pop", 64'(pc_q.size() - b), 64'd0);
        spur_data = 32'hDEAD_BEEF;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        chk("t2_spur_pc", out_pc, 64'd0);
        chk("t2_spur_req", imem_req, 1'b0);
        b = pc_q.size();
        stall = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_drain_pc", pc_q[b+i], 64'(i * 4));
        end
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_gap", 64'(cyc_q[b+i+1] - cyc_q[b+i]), 64'd1);
        end

        // T3: redirect while waiting on a slow fetch of 0x8
        do_reset(3, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (imem_req && imem_addr == 64'h8 && !imem_ack) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("t3_reach_8", ok, 1'b1);
        redirect_pc = 64'h100;
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        chk("t3_req_drop", imem_req, 1'b0);
        chk("t3_flushed", out_valid, 1'b0);
        b = pc_q.size();
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            chk("t3_no_valid", out_valid, 1'b0);
            tick();
        end
        chk("t3_req_seen", ok, 1'b1);
        chk("t3_req_addr", imem_addr, 64'h100);
        repeat (12) tick();
        chk("t3_first_pc", pc_q[b], 64'h100);
        chk("t3_first_inst", inst_q[b], 64'(mem_f(64'h100)));
        chk("t3_second_pc", pc_q[b+1], 64'h104);

        // T4: redirect on the same edge as the ack for 0x8
        do_reset(1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (imem_ack && imem_req && imem_addr == 64'h8) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("t4_reach_ack8", ok, 1'b1);
        redirect_pc = 64'h40;
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        chk("t4_req_low", imem_req, 1'b0);
        chk("t4_flushed", out_valid, 1'b0);
        b = pc_q.size();
        tick();
        chk("t4_req_next", imem_req, 1'b1);
        chk("t4_addr_next", imem_addr, 64'h40);
        repeat (8) tick();
        chk("t4_first_pc", pc_q[b], 64'h40);
        chk("t4_second_pc", pc_q[b+1], 64'h44);

        // T5: PC wraps past 2^64 and queue order survives pointer wrap
        do_reset(1, 1'b1);
        repeat (2) tick();
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        repeat (20) tick();
        chk("t5_head", out_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("t5_req_low", imem_req, 1'b0);
        b = pc_q.size();
        stall = 1'b0;
        repeat (16) tick();
        chk("t5_pc0", pc_q[b],   64'hFFFF_FFFF_FFFF_FFF8);
        chk("t5_pc1", pc_q[b+1], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_pc2", pc_q[b+2], 64'h0);
        chk("t5_pc3", pc_q[b+3], 64'h4);
        chk("t5_pc4", pc_q[b+4], 64'h8);
        chk("t5_pc5", pc_q[b+5], 64'hC);
        chk("t5_inst2", inst_q[b+2], 64'(mem_f(64'h0)));

        // T6: asynchronous reset mid-WAIT with a filled queue
        do_reset(3, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (imem_req && imem_addr == 64'hC) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("t6_reach_c", ok, 1'b1);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("t6_req", imem_req, 1'b0);
        chk("t6_addr", imem_addr, 64'd0);
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_pc", out_pc, 64'd0);
        chk("t6_inst", out_inst, 32'd0);
        repeat (6) tick();
        chk("t6_valid_hold", out_valid, 1'b0);
        b = pc_q.size();
        stall = 1'b0;
        rst = 1'b1;
        tick();
        chk("t6_req_after", imem_req, 1'b1);
        chk("t6_addr_after", imem_addr, 64'd0);
        repeat (16) tick();
        chk("t6_pc0", pc_q[b], 64'h0);
        chk("t6_pc1", pc_q[b+1], 64'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
